apb_node_tmo: RTL and testbench

//  Registered APB 1:N demux: upstream APB transfer routed to one of NB_MASTER downstream ports by address range.

---
 rtl/apb_node_tmo.sv | 162 ++++++++++++++++
 tb/tb_apb_node_tmo.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_node_tmo.sv
// Registered APB 1:N node with address decode,
// decode-error response and per-access watchdog.
module apb_node_tmo #(
  parameter int NB_MASTER      = 8,
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                psel_i,
  input  logic                                penable_i,
  input  logic                                pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0]           paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]           pwdata_i,
  output logic [APB_DATA_WIDTH-1:0]           prdata_o,
  output logic                                pready_o,
  output logic                                pslverr_o,
  output logic [NB_MASTER-1:0]                psel_o,
  output logic [NB_MASTER-1:0]                penable_o,
  output logic [NB_MASTER-1:0]                pwrite_o,
  output logic [NB_MASTER*APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [NB_MASTER*APB_DATA_WIDTH-1:0] pwdata_o,
  input  logic [NB_MASTER*APB_DATA_WIDTH-1:0] prdata_i,
  input  logic [NB_MASTER-1:0]                pready_i,
  input  logic [NB_MASTER-1:0]                pslverr_i,
  input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] end_addr_i,
  output logic                                decerr_o,
  output logic                                timeout_o
);

  localparam int AW    = APB_ADDR_WIDTH;
  localparam int DW    = APB_DATA_WIDTH;
  localparam int IW    = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
  localparam int TW    = (TIMEOUT_CYCLES > 0) ?
                         $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TLAST = (TIMEOUT_CYCLES > 0) ?
                         TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            write_q;
  logic [IW-1:0]   idx_q;
  logic            hit_q;
  logic [DW-1:0]   rdata_q;
  logic            err_q;
  logic [TW-1:0]   timer_q;
  logic            decerr_q;
  logic            timeout_q;

  logic            dec_hit;
  logic [IW-1:0]   dec_idx;
  logic [NB_MASTER-1:0] onehot;
  logic [DW-1:0]   sel_rdata;
  logic            sel_ready;
  logic            sel_err;

  // Address decode: lowest-numbered matching range wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NB_MASTER - 1; i >= 0; i--) begin
      if (paddr_i >= start_addr_i[i*AW +: AW] &&
          paddr_i <= end_addr_i[i*AW +: AW]) begin
        dec_hit = 1'b1;
        dec_idx = IW'(i);
      end
    end
  end

  assign onehot    = NB_MASTER'(1) << idx_q;
  assign sel_rdata = prdata_i[idx_q*DW +: DW];
  assign sel_ready = pready_i[idx_q];
  assign sel_err   = pslverr_i[idx_q];

  // Transfer FSM with latched request, response and watchdog.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      hit_q     <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timer_q   <= '0;
      decerr_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      decerr_q  <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (psel_i && !penable_i) begin
            addr_q  <= paddr_i;
            wdata_q <= pwdata_i;
            write_q <= pwrite_i;
            idx_q   <= dec_idx;
            hit_q   <= dec_hit;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (hit_q) begin
            timer_q <= '0;
            state_q <= ACCESS;
          end else begin
            rdata_q  <= '0;
            err_q    <= 1'b1;
            decerr_q <= 1'b1;
            state_q  <= RESP;
          end
        end
        ACCESS: begin
          if (sel_ready) begin
            rdata_q <= sel_rdata;
            err_q   <= sel_err;
            state_q <= RESP;
          end else if (TIMEOUT_CYCLES != 0 &&
                       timer_q == TW'(TLAST)) begin
            rdata_q   <= '0;
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= RESP;
          end else if (TIMEOUT_CYCLES != 0) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RESP: begin
          if (!psel_i || penable_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign psel_o    = ((state_q == SETUP && hit_q) ||
                      state_q == ACCESS) ? onehot : '0;
  assign penable_o = (state_q == ACCESS) ? onehot : '0;
  assign pwrite_o  = {NB_MASTER{write_q}};
  assign paddr_o   = {NB_MASTER{addr_q}};
  assign pwdata_o  = {NB_MASTER{wdata_q}};

  assign pready_o  = (state_q == RESP) && psel_i && penable_i;
  assign prdata_o  = pready_o ? rdata_q : '0;
  assign pslverr_o = pready_o & err_q;
  assign decerr_o  = decerr_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_apb_node_tmo.sv
// Randomized bench for apb_node_tmo against
// a transfer-level latency/response model.
module tb_apb_node_tmo;

  localparam int NB = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          psel_i, penable_i, pwrite_i;
  logic [31:0]   paddr_i, pwdata_i;
  logic [31:0]   prdata_o;
  logic          pready_o, pslverr_o;
  logic [NB-1:0] psel_o, penable_o, pwrite_o;
  logic [NB*32-1:0] paddr_o, pwdata_o;
  logic [NB*32-1:0] prdata_i;
  logic [NB-1:0] pready_i, pslverr_i;
  logic [NB*32-1:0] start_f, end_f;
  logic          decerr_o, timeout_o;

  logic [31:0]   st [NB];
  logic [31:0]   en [NB];
  logic [31:0]   sl_rdata [NB];
  logic [NB-1:0] sl_err;
  int            w_cur;
  int            acc_cnt;
  int            n_chk;
  int            n_pass;

  always #5 clk = ~clk;

  apb_node_tmo #(
    .NB_MASTER(NB),
    .APB_DATA_WIDTH(32),
    .APB_ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .psel_i(psel_i),
    .penable_i(penable_i),
    .pwrite_i(pwrite_i),
    .paddr_i(paddr_i),
    .pwdata_i(pwdata_i),
    .prdata_o(prdata_o),
    .pready_o(pready_o),
    .pslverr_o(pslverr_o),
    .psel_o(psel_o),
    .penable_o(penable_o),
    .pwrite_o(pwrite_o),
    .paddr_o(paddr_o),
    .pwdata_o(pwdata_o),
    .prdata_i(prdata_i),
    .pready_i(pready_i),
    .pslverr_i(pslverr_i),
    .start_addr_i(start_f),
    .end_addr_i(end_f),
    .decerr_o(decerr_o),
    .timeout_o(timeout_o)
  );

  // Slave side: each port waits w_cur ACCESS cycles.
  always_comb begin
    start_f  = '0;
    end_f    = '0;
    prdata_i = '0;
    pready_i = '0;
    for (int i = 0; i < NB; i++) begin
      start_f[i*32 +: 32]  = st[i];
      end_f[i*32 +: 32]    = en[i];
      prdata_i[i*32 +: 32] = sl_rdata[i];
      pready_i[i] = penable_o[i] && (acc_cnt >= w_cur);
    end
    pslverr_i = sl_err;
  end

  always @(posedge clk) begin
    if (|penable_o) acc_cnt <= acc_cnt + 1;
    else            acc_cnt <= 0;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  tag, obs, exp);
  endtask

  task automatic set_ranges_default();
    for (int i = 0; i < NB; i++) begin
      st[i] = 32'(i * 32'h100);
      en[i] = 32'(i * 32'h100 + 32'hFF);
    end
  endtask

  // One full upstream transfer; caller is at a negedge.
  task automatic xfer(input logic [31:0] a,
                      input logic        wr,
                      input logic [31:0] wd,
                      input int          w);
    int          port;
    int          lat;
    int          c;
    logic [31:0] erd;
    logic        eerr;
    logic [NB-1:0] psel1;
    logic        got, sdec, sto;
    logic [31:0] ord, oad, owd;
    logic        oerr, owr;
    port = -1;
    for (int i = NB - 1; i >= 0; i--)
      if (st[i] <= a && a <= en[i]) port = i;
    for (int k = 0; k < NB; k++) sl_rdata[k] = $urandom;
    sl_err = NB'($urandom);
    w_cur  = w;
    if (port < 0) begin
      lat = 2; erd = 0; eerr = 1'b1;
    end else if (w >= TO) begin
      lat = TO + 2; erd = 0; eerr = 1'b1;
    end else begin
      lat = 3 + w; erd = sl_rdata[port]; eerr = sl_err[port];
    end
    psel_i = 1'b1; penable_i = 1'b0;
    paddr_i = a; pwrite_i = wr; pwdata_i = wd;
    @(negedge clk);
    c = 1;
    psel1 = psel_o;
    penable_i = 1'b1;
    paddr_i = $urandom; pwdata_i = $urandom;
    pwrite_i = ~wr;
    got = 0; sdec = 0; sto = 0;
    ord = 0; oerr = 0; oad = 0; owd = 0; owr = 0;
    while (1) begin
      sdec |= decerr_o;
      sto  |= timeout_o;
      if (pready_o) begin
        got = 1;
        ord = prdata_o; oerr = pslverr_o;
        oad = paddr_o[NB*32-1 -: 32];
        owd = pwdata_o[31:0];
        owr = pwrite_o[1];
        break;
      end
      if (c >= 40) break;
      @(negedge clk);
      c++;
    end
    chk("ready", 64'(got), 64'd1);
    chk("latency", 64'(c), 64'(lat));
    chk("psel", 64'(psel1),
        (port < 0) ? 64'd0 : (64'd1 << port));
    chk("prdata", 64'(ord), 64'(erd));
    chk("pslverr", 64'(oerr), 64'(eerr));
    chk("decerr", 64'(sdec), 64'(port < 0));
    chk("timeout", 64'(sto), 64'(port >= 0 && w >= TO));
    chk("paddr", 64'(oad), 64'(a));
    chk("pwdata", 64'(owd), 64'(wd));
    chk("pwrite", 64'(owr), 64'(wr));
    psel_i = 1'b0; penable_i = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'(pready_o), 64'd0);
  endtask

  initial begin
    int r, w, p;
    logic [31:0] a;
    n_chk = 0; n_pass = 0;
    acc_cnt = 0; w_cur = 0;
    rst_n = 1'b0;
    psel_i = 0; penable_i = 0; pwrite_i = 0;
    paddr_i = 0; pwdata_i = 0;
    sl_err = '0;
    for (int k = 0; k < NB; k++) sl_rdata[k] = 32'hFFFF_FFFF;
    set_ranges_default();
    repeat (2) @(negedge clk);
    chk("rst_psel", 64'(psel_o), 64'd0);
    chk("rst_pen", 64'(penable_o), 64'd0);
    chk("rst_ready", 64'(pready_o), 64'd0);
    chk("rst_prdata", 64'(prdata_o), 64'd0);
    chk("rst_flags", 64'({decerr_o, timeout_o, pslverr_o}), 64'd0);
    chk("rst_paddr", 64'(|paddr_o), 64'd0);
    chk("rst_pwdata", 64'(|{pwdata_o, pwrite_o}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    xfer(32'h1A4, 1'b0, 32'h0, 0);
    xfer(32'h2F0, 1'b1, 32'h55, 5);
    xfer(32'h800, 1'b0, 32'h0, 0);
    xfer(32'h010, 1'b0, 32'h0, 1000);
    xfer(32'h010, 1'b0, 32'h0, TO - 1);
    xfer(32'h3FF, 1'b1, 32'hA5A5, 1);
    xfer(32'h400, 1'b0, 32'h0, 0);

    // Overlapping ranges and an inverted range.
    st[0] = 32'h500;  en[0] = 32'h400;
    st[1] = 32'h0;    en[1] = 32'hFFF;
    st[2] = 32'h100;  en[2] = 32'h1FF;
    st[3] = 32'h2000; en[3] = 32'h2FFF;
    xfer(32'h150, 1'b0, 32'h0, 0);
    xfer(32'h2000, 1'b1, 32'h77, 2);
    st[1] = 32'h0;    en[1] = 32'hFF;
    xfer(32'h450, 1'b0, 32'h0, 0);
    set_ranges_default();

    // Upstream abandons before the response.
    w_cur = 0;
    psel_i = 1; penable_i = 0; paddr_i = 32'h120; pwrite_i = 0;
    @(negedge clk);
    penable_i = 1;
    @(negedge clk);
    psel_i = 0; penable_i = 0;
    @(negedge clk);
    chk("abandon_ready", 64'(pready_o), 64'd0);
    @(negedge clk);
    xfer(32'h220, 1'b0, 32'h0, 1);

    // Reset in the middle of ACCESS.
    w_cur = 1000;
    psel_i = 1; penable_i = 0; paddr_i = 32'h330; pwrite_i = 1;
    pwdata_i = 32'h1234;
    @(negedge clk);
    penable_i = 1;
    @(negedge clk);
    chk("mid_pen", 64'(penable_o), 64'b1000);
    rst_n = 1'b0;
    #1;
    chk("mid_psel", 64'(psel_o), 64'd0);
    chk("mid_pen0", 64'(penable_o), 64'd0);
    chk("mid_ready", 64'(pready_o), 64'd0);
    chk("mid_paddr", 64'(|{paddr_o, pwdata_o, pwrite_o}), 64'd0);
    psel_i = 0; penable_i = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(32'h330, 1'b1, 32'h1234, 0);

    // Randomized traffic over the default map.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 5);
      p = $urandom_range(0, NB - 1);
      if (r <= 2)      a = 32'($urandom_range(0, 32'h3FF));
      else if (r == 3) a = 32'($urandom_range(32'h400, 32'hFFFF));
      else if (r == 4) a = st[p];
      else             a = en[p];
      r = $urandom_range(0, 9);
      w = (r < 7) ? (r % 4) : (TO - 3 + $urandom_range(0, 5));
      xfer(a, 1'($urandom), $urandom, w);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
